// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse key front-end and decoder benches.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRESS = 3'd1,
    GAP   = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4
  } state_e;

  localparam int unsigned DEB_CYC_DEF    = 4;
  localparam int unsigned DASH_MIN_DEF   = 24;
  localparam int unsigned LETTER_GAP_DEF = 32;
  localparam int unsigned HOLD_CYC_DEF   = 64;
  localparam int unsigned MAX_SYM_DEF    = 5;
  localparam int unsigned CW_DEF         = 8;
  localparam int unsigned SYM_W          = 3;

endpackage

// File: rtl/morse_key_sequencer_if.sv
// Key input and decoder-facing outputs of the Morse key sequencer.
interface morse_key_sequencer_if;
  import morse_pkg::*;

  logic             key;
  logic             dot;
  logic             dash;
  logic             dec_clear;
  logic             letter_done;
  logic [SYM_W-1:0] sym_count;
  logic             overflow;
  logic             busy;

  modport master (
    output key,
    input  dot, dash, dec_clear, letter_done, sym_count, overflow, busy
  );

  modport slave (
    input  key,
    output dot, dash, dec_clear, letter_done, sym_count, overflow, busy
  );
endinterface

// File: rtl/morse_key_sequencer_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for the raw key.
module key_debouncer #(
  parameter int unsigned DEB_CYC = morse_pkg::DEB_CYC_DEF
) (
  input  logic Clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_db
);
  localparam int unsigned DW = $clog2(DEB_CYC + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [DW-1:0] r_cnt;

  // Any cycle agreeing with the debounced level restarts the stability count.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_db) begin
        if (r_cnt == DW'(DEB_CYC - 1)) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign key_db = r_db;
endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key front-end: classifies debounced presses as dot/dash, counts symbols
// per letter, and sequences the letter-done and decoder-clear pulses.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned DEB_CYC    = DEB_CYC_DEF,
  parameter int unsigned DASH_MIN   = DASH_MIN_DEF,
  parameter int unsigned LETTER_GAP = LETTER_GAP_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned MAX_SYM    = MAX_SYM_DEF,
  parameter int unsigned CW         = CW_DEF
) (
  input logic                  Clock,
  input logic                  reset,
  morse_key_sequencer_if.slave bus
);
  logic             w_key_db;
  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [SYM_W-1:0] r_sym, w_sym_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_dot, w_dot_nxt;
  logic             r_dash, w_dash_nxt;
  logic             r_clear, w_clear_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;

  key_debouncer #(.DEB_CYC(DEB_CYC)) u_deb (
    .Clock   (Clock),
    .reset   (reset),
    .key_raw (bus.key),
    .key_db  (w_key_db)
  );

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sym   <= '0;
      r_ovf   <= 1'b0;
      r_dot   <= 1'b0;
      r_dash  <= 1'b0;
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym   <= w_sym_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dot   <= w_dot_nxt;
      r_dash  <= w_dash_nxt;
      r_clear <= w_clear_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Pulses are produced on the transition so they land with the new state and counts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    w_sym_nxt   = r_sym;
    w_ovf_nxt   = r_ovf;
    w_dot_nxt   = 1'b0;
    w_dash_nxt  = 1'b0;
    w_clear_nxt = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_key_db) begin
          w_state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (!w_key_db) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
          if (r_sym < SYM_W'(MAX_SYM)) begin
            w_dot_nxt  = (r_cnt < CW'(DASH_MIN));
            w_dash_nxt = (r_cnt >= CW'(DASH_MIN));
            w_sym_nxt  = r_sym + SYM_W'(1);
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_key_db) begin
          w_state_nxt = PRESS;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(LETTER_GAP - 1)) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (w_key_db) begin
          w_state_nxt = PRESS;
          w_cnt_nxt   = '0;
          w_clear_nxt = 1'b1;
          w_sym_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (r_cnt == CW'(HOLD_CYC - 1)) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_clear_nxt = 1'b1;
          w_sym_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      CLEAR: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.dot         = r_dot;
  assign bus.dash        = r_dash;
  assign bus.dec_clear   = r_clear;
  assign bus.letter_done = r_done;
  assign bus.sym_count   = r_sym;
  assign bus.overflow    = r_ovf;
  assign bus.busy        = r_busy;
endmodule
